// File: rtl/four_bank_mem_pkg.sv
// Shared constants and request decode for the four-bank interleaved main memory.
package mem_pkg;
   localparam int NUM_BANKS        = 4;
   localparam int BANK_BUSY_CYCLES = 4;
   localparam int READ_LATENCY     = 2;
   localparam int DATA_W           = 16;
   localparam int ADDR_W           = 16;
   localparam int BANK_W           = $clog2(NUM_BANKS);
   localparam int ROW_W            = ADDR_W - BANK_W - 1;
   localparam int CNT_W            = $clog2(BANK_BUSY_CYCLES);

   typedef enum logic [1:0] {IDLE, READ, WRITE, ILLEGAL} req_t;

   // Classify one cycle's request; odd byte addresses and Rd&Wr are illegal.
   function automatic req_t decode_req(input logic rd, input logic wr, input logic a0);
      if (!rd && !wr)     return IDLE;
      else if (rd && wr)  return ILLEGAL;
      else if (a0)        return ILLEGAL;
      else if (rd)        return READ;
      else                return WRITE;
   endfunction
endpackage

// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller and the main memory.
interface four_bank_mem_if;
   import mem_pkg::*;

   logic [ADDR_W-1:0]    Addr;
   logic [DATA_W-1:0]    DataIn;
   logic                 Rd;
   logic                 Wr;
   logic [DATA_W-1:0]    DataOut;
   logic                 DataOut_vld;
   logic                 Stall;
   logic [NUM_BANKS-1:0] Busy;
   logic                 err;

   modport master (output Addr, DataIn, Rd, Wr,
                   input  DataOut, DataOut_vld, Stall, Busy, err);
   modport slave  (input  Addr, DataIn, Rd, Wr,
                   output DataOut, DataOut_vld, Stall, Busy, err);
endinterface

// File: rtl/four_bank_mem_bank.sv
// One memory bank: word array, occupancy counter and stage-1 read register.
module mem_bank
   import mem_pkg::*;
#(
   parameter int ROWS = 8192,
   localparam int RW  = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc,      // accepted access to this bank this edge
   input  logic              wr,       // accepted access is a write
   input  logic [RW-1:0]     row,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] rd_data,  // stage-1 read register
   output logic              busy
);
   logic [DATA_W-1:0] mem [ROWS];
   logic [CNT_W-1:0]  cnt;
   logic [RW-1:0]     row_q;

   // Array write; contents survive reset.
   always_ff @(posedge clk)
      if (acc && wr) mem[row] <= din;

   // Occupancy: reload on access, otherwise count down to idle.
   always_ff @(posedge clk or negedge rst)
      if (!rst)          cnt <= '0;
      else if (acc)      cnt <= CNT_W'(BANK_BUSY_CYCLES - 1);
      else if (cnt != 0) cnt <= cnt - 1'b1;

   // Capture the row of an accepted read.
   always_ff @(posedge clk or negedge rst)
      if (!rst)            row_q <= '0;
      else if (acc && !wr) row_q <= row;

   // Stage 1: array read. The bank is busy for the whole return, so no write
   // can slip in between capture and this read.
   always_ff @(posedge clk)
      rd_data <= mem[row_q];

   assign busy = (cnt != 0);
endmodule

// File: rtl/four_bank_mem.sv
// Four-bank word-interleaved main memory: decode, stall/err, stage-2 output.
module four_bank_mem
   import mem_pkg::*;
#(
   parameter int ROWS = 8192
) (
   input  logic           clk,
   input  logic           rst,
   four_bank_mem_if.slave bus
);
   localparam int RW = $clog2(ROWS);

   req_t                                 req;
   logic [BANK_W-1:0]                    bank;
   logic [ROW_W-1:0]                     row_full;
   logic [RW-1:0]                        row;
   logic                                 stall;
   logic                                 acc_any;
   logic                                 rd_acc;
   logic [NUM_BANKS-1:0]                 acc;
   logic [NUM_BANKS-1:0]                 busy;
   logic [NUM_BANKS-1:0][DATA_W-1:0]     rd_data;
   logic [READ_LATENCY:0]                vld_pipe;
   logic [READ_LATENCY-1:0][BANK_W-1:0]  bank_pipe;
   logic [DATA_W-1:0]                    dout;
   logic                                 err_q;

   // Request decode, bank conflict stall and one-hot bank accept.
   always_comb begin
      req      = decode_req(bus.Rd, bus.Wr, bus.Addr[0]);
      bank     = bus.Addr[BANK_W:1];
      row_full = bus.Addr[ADDR_W-1:BANK_W+1];
      row      = row_full[RW-1:0];
      stall    = (bus.Rd | bus.Wr) & busy[bank];
      acc_any  = ((req == READ) || (req == WRITE)) && !stall;
      rd_acc   = acc_any && (req == READ);
      acc      = '0;
      if (acc_any) acc[bank] = 1'b1;
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      mem_bank #(.ROWS(ROWS)) u_bank (
         .clk     (clk),
         .rst     (rst),
         .acc     (acc[g]),
         .wr      (req == WRITE),
         .row     (row),
         .din     (bus.DataIn),
         .rd_data (rd_data[g]),
         .busy    (busy[g])
      );
   end

   // Read return pipeline: valid bits and bank tags shift alongside the data.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         vld_pipe  <= '0;
         bank_pipe <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[READ_LATENCY-1:0], rd_acc};
         bank_pipe <= {bank_pipe[READ_LATENCY-2:0], bank};
      end

   // Stage 2: select the returning bank; hold DataOut between returns.
   always_ff @(posedge clk or negedge rst)
      if (!rst)                             dout <= '0;
      else if (vld_pipe[READ_LATENCY-1])    dout <= rd_data[bank_pipe[READ_LATENCY-1]];

   // Illegal requests flag for one cycle.
   always_ff @(posedge clk or negedge rst)
      if (!rst) err_q <= 1'b0;
      else      err_q <= (req == ILLEGAL);

   assign bus.DataOut     = dout;
   assign bus.DataOut_vld = vld_pipe[READ_LATENCY];
   assign bus.Stall       = stall;
   assign bus.Busy        = busy;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_four_bank_mem.sv
// Directed bench for four_bank_mem: banking, stalls, latency, errors, reset.
module tb_four_bank_mem;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   four_bank_mem_if bus ();

   four_bank_mem #(.ROWS(8192)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
      bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
   endtask

   task automatic idle;
      drive(1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic idle_n(input int n);
      idle();
      for (int i = 0; i < n; i++) tick();
   endtask

   // Hold a request until its bank frees, bounded; leaves it accepted at the edge.
   task automatic issue(input string tag, input logic rd, input logic [15:0] a, input logic [15:0] d);
      int n;
      n = 0;
      drive(rd, !rd, a, d);
      #1;
      while (bus.Stall && n < 8) begin
         tick();
         n++;
      end
      if (n >= 8) chk({tag, "_stall_timeout"}, 32'(n), 32'd0);
      tick();
      idle();
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
      issue(tag, 1'b1, a, 16'h0);
      tick();
      tick();
      chk({tag, "_vld"}, bus.DataOut_vld, 1'b1);
      chk({tag, "_data"}, bus.DataOut, exp);
   endtask

   logic [3:0]  busy_exp [7];
   logic [15:0] e;

   initial begin
      busy_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      idle();

      // Reset state
      tick(); tick();
      chk("rst_dout",  bus.DataOut, 16'h0);
      chk("rst_vld",   bus.DataOut_vld, 1'b0);
      chk("rst_busy",  bus.Busy, 4'b0);
      chk("rst_stall", bus.Stall, 1'b0);
      chk("rst_err",   bus.err, 1'b0);
      rst = 1'b1;
      tick();

      // Line write to banks 0..3 back to back; occupancy fills and drains
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'h1111 * (i + 1)));
         #1;
         chk($sformatf("wr_stall%0d", i), bus.Stall, 1'b0);
         tick();
         chk($sformatf("wr_busy%0d", i), bus.Busy, busy_exp[i]);
      end
      idle();
      for (int k = 4; k < 7; k++) begin
         tick();
         chk($sformatf("drain_busy%0d", k), bus.Busy, busy_exp[k]);
      end

      // Line fill: returns two cycles after each accept
      for (int k = 0; k < 7; k++) begin
         if (k < 4) drive(1'b1, 1'b0, 16'(16'h0100 + 2 * k), 16'h0);
         else       idle();
         #1;
         if (k < 4) chk($sformatf("fill_stall%0d", k), bus.Stall, 1'b0);
         tick();
         chk($sformatf("fill_vld%0d", k), bus.DataOut_vld, (k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) begin
            e = 16'(16'h1111 * (k - 1));
            chk($sformatf("fill_data%0d", k), bus.DataOut, e);
         end
      end
      chk("dout_hold", bus.DataOut, 16'h4444);

      // Same-bank conflict: read held 3 cycles, returns pre-write content
      issue("pre", 1'b0, 16'h0208, 16'h7777);
      idle_n(4);
      drive(1'b0, 1'b1, 16'h0200, 16'hBEEF);
      tick();
      drive(1'b1, 1'b0, 16'h0208, 16'h0);
      for (int j = 0; j < 3; j++) begin
         #1;
         chk($sformatf("conf_stall%0d", j), bus.Stall, 1'b1);
         tick();
      end
      #1;
      chk("conf_stall_clr", bus.Stall, 1'b0);
      tick();
      idle();
      tick();
      chk("conf_vld_early", bus.DataOut_vld, 1'b0);
      tick();
      chk("conf_vld",  bus.DataOut_vld, 1'b1);
      chk("conf_data", bus.DataOut, 16'h7777);
      rd_chk("beef", 16'h0200, 16'hBEEF);

      // Illegal requests: err pulse, no access, no occupancy
      issue("pre10", 1'b0, 16'h0010, 16'h1234);
      idle_n(4);
      drive(1'b1, 1'b1, 16'h0010, 16'hDEAD);
      tick();
      chk("ill_rw_err",  bus.err, 1'b1);
      chk("ill_rw_busy", bus.Busy, 4'b0);
      idle();
      tick();
      chk("ill_rw_err_clr", bus.err, 1'b0);
      drive(1'b1, 1'b0, 16'h0011, 16'h0);
      tick();
      chk("ill_odd_err",  bus.err, 1'b1);
      chk("ill_odd_busy", bus.Busy, 4'b0);
      idle();
      tick();
      chk("ill_odd_err_clr", bus.err, 1'b0);
      tick();
      chk("ill_odd_novld", bus.DataOut_vld, 1'b0);
      rd_chk("ill_mem", 16'h0010, 16'h1234);

      // Reset with a read in flight
      idle_n(4);
      drive(1'b1, 1'b0, 16'h0100, 16'h0);
      tick();
      idle();
      tick();
      #2 rst = 1'b0;
      #1;
      chk("mrst_dout", bus.DataOut, 16'h0);
      chk("mrst_vld",  bus.DataOut_vld, 1'b0);
      chk("mrst_busy", bus.Busy, 4'b0);
      e = '0;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) rst = 1'b1;
         tick();
         e = e | 16'(bus.DataOut_vld);
      end
      chk("mrst_no_vld", e, 16'h0);
      rd_chk("mrst_keep", 16'h0100, 16'h1111);

      // Write bank 2 then read bank 3 on the next edge: independent
      idle_n(4);
      drive(1'b0, 1'b1, 16'h0304, 16'hA5A5);
      #1;
      chk("xb_wr_stall", bus.Stall, 1'b0);
      tick();
      drive(1'b1, 1'b0, 16'h0106, 16'h0);
      #1;
      chk("xb_rd_stall", bus.Stall, 1'b0);
      tick();
      idle();
      tick();
      chk("xb_busy", bus.Busy, 4'b1100);
      chk("xb_vld_early", bus.DataOut_vld, 1'b0);
      tick();
      chk("xb_vld",  bus.DataOut_vld, 1'b1);
      chk("xb_data", bus.DataOut, 16'h4444);
      rd_chk("xb_a5", 16'h0304, 16'hA5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
